digit_serial_mul_ctrl: RTL and testbench

Sequencing controller that builds a WIDTH×WIDTH unsigned product from one shared 2-bit×2-bit multiplier core (hand-built or RL-generated). It walks every pair of 2-bit digits of the operands, drives the core combinationally, and accumulates each 4-bit core result at weight 4^(i+j). It also checks every core result against the exact 2×2 product and counts mismatches. It sits between the candidate-core instance and the bench/scoreboard, so small cores can be evaluated at higher bit widths.

---
 rtl/digit_serial_mul_ctrl.sv | 131 +++++++++++++
 tb/tb_digit_serial_mul_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_mul_ctrl.sv
// Digit-serial WIDTHxWIDTH unsigned multiplier controller around a shared 2x2 core.
// Walks all digit pairs, accumulates core results and audits each one against the exact product.
module digit_serial_mul_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               clr_err,
    output logic [1:0]         core_a,
    output logic [1:0]         core_b,
    input  logic [3:0]         core_p,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic               core_err,
    output logic [7:0]         err_cnt
);

    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam logic [IdxW-1:0] Last = IdxW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IdxW-1:0]   i_q, j_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     p_q;
    logic              busy_q, done_q;
    logic              err_q;
    logic [7:0]        cnt_q;

    logic [IdxW+1:0]   shamt;
    logic [PW-1:0]     term;
    logic [PW-1:0]     acc_sum;
    logic [3:0]        exact;
    logic              mismatch;
    logic              last_pair;

    // Core operands come straight from the latched operands; zero outside CALC so an
    // asynchronous reset clears them without waiting for an edge.
    always_comb begin
        core_a = 2'b00;
        core_b = 2'b00;
        if (state_q == StCalc) begin
            core_a = a_q[{i_q, 1'b0} +: 2];
            core_b = b_q[{j_q, 1'b0} +: 2];
        end
    end

    always_comb begin
        shamt     = ({2'b00, i_q} + {2'b00, j_q}) << 1;
        term      = PW'(core_p) << shamt;
        acc_sum   = acc_q + term;
        exact     = {2'b00, core_a} * {2'b00, core_b};
        mismatch  = (state_q == StCalc) && (core_p != exact);
        last_pair = (i_q == Last) && (j_q == Last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        i_q     <= '0;
                        j_q     <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    acc_q <= acc_sum;
                    if (j_q == Last) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (last_pair) begin
                        p_q     <= acc_sum;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A clear wins over a same-cycle mismatch, which is then dropped.
            if (clr_err) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end else if (mismatch) begin
                err_q <= 1'b1;
                if (cnt_q != 8'hFF) begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign p        = p_q;
    assign core_err = err_q;
    assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_digit_serial_mul_ctrl.sv
// Directed and table-driven bench for digit_serial_mul_ctrl with an exact or faulty 2x2 core model.
module tb_digit_serial_mul_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a, b;
    logic        clr_err;
    logic [1:0]  core_a, core_b;
    logic [3:0]  core_p;
    logic        busy, done;
    logic [15:0] p;
    logic        core_err;
    logic [7:0]  err_cnt;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    digit_serial_mul_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .clr_err  (clr_err),
        .core_a   (core_a),
        .core_b   (core_b),
        .core_p   (core_p),
        .busy     (busy),
        .done     (done),
        .p        (p),
        .core_err (core_err),
        .err_cnt  (err_cnt)
    );

    // Candidate core: exact, or returns 8 for 3x3 when faulty.
    always_comb begin
        core_p = {2'b00, core_a} * {2'b00, core_b};
        if (fault && core_a == 2'd3 && core_b == 2'd3) core_p = 4'd8;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        fault;
        logic [15:0] exp_p;
        logic        exp_err;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Launch one product, check latency, busy length, result and single-cycle done.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp_p,
                          input string tag);
        int lat  = 0;
        int bcnt = 0;
        a = ta;
        b = tb_v;
        start = 1'b1;
        do begin
            tick();
            if (lat == 0) start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 40);
        check({tag, " latency"}, 64'(lat), 64'd17);
        check({tag, " busy_cycles"}, 64'(bcnt), 64'd16);
        check({tag, " p"}, 64'(p), 64'(exp_p));
        tick();
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        logic [7:0]  ra, rb;
        logic [7:0]  exp_cnt;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 8'd0};
        vecs[1] = '{8'h00, 8'hA5, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 16'h0080, 1'b0, 8'd0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, 8'd0};
        vecs[4] = '{8'h03, 8'h03, 1'b1, 16'h0008, 1'b1, 8'd1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 16'hE1C8, 1'b1, 8'd16};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; clr_err = 1'b0; fault = 1'b0;
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset p", 64'(p), 64'd0);
        check("reset core_a", 64'(core_a), 64'd0);
        check("reset core_b", 64'(core_b), 64'd0);
        check("reset core_err", 64'(core_err), 64'd0);
        check("reset err_cnt", 64'(err_cnt), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            fault = vecs[k].fault;
            clear_errors();
            run_op(vecs[k].a, vecs[k].b, vecs[k].exp_p, $sformatf("vec%0d", k));
            check($sformatf("vec%0d core_err", k), 64'(core_err), 64'(vecs[k].exp_err));
            check($sformatf("vec%0d err_cnt", k), 64'(err_cnt), 64'(vecs[k].exp_cnt));
        end

        fault = 1'b0;
        clear_errors();
        for (int k = 0; k < 500; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), $sformatf("rand%0d", k));
        end
        check("rand err_cnt", 64'(err_cnt), 64'd0);

        // start held high, operands changed mid-op, back-to-back relaunch from DONE.
        a = 8'h5A; b = 8'hC3; start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 3) begin a = 8'h11; b = 8'h22; end
        end while (!done && lat < 40);
        check("hold latency", 64'(lat), 64'd17);
        check("hold p", 64'(p), 64'h448E);
        tick();
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b done", 64'(done), 64'd0);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b latency", 64'(lat), 64'd17);
        check("b2b p", 64'(p), 64'h0242);
        tick();

        // Asynchronous reset in CALC cycle 5.
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre-rst busy", 64'(busy), 64'd1);
        check("pre-rst core_a", 64'(core_a), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst done", 64'(done), 64'd0);
        check("arst p", 64'(p), 64'd0);
        check("arst core_a", 64'(core_a), 64'd0);
        check("arst core_b", 64'(core_b), 64'd0);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (busy || done) begin
                check("post-rst idle", 64'({busy, done}), 64'd0);
                break;
            end
        end
        check("post-rst p", 64'(p), 64'd0);
        run_op(8'h07, 8'h09, 16'h003F, "post-rst op");

        // Saturation: every digit pair of 0xFF x 0xFF mismatches under the faulty core.
        fault = 1'b1;
        clear_errors();
        for (int k = 0; k < 19; k++) begin
            run_op(8'hFF, 8'hFF, 16'hE1C8, $sformatf("sat%0d", k));
            exp_cnt = (16 * (k + 1) > 255) ? 8'd255 : 8'(16 * (k + 1));
            check($sformatf("sat%0d err_cnt", k), 64'(err_cnt), 64'(exp_cnt));
        end
        check("sat core_err", 64'(core_err), 64'd1);

        // clr_err in the same cycle as a mismatch.
        start = 1'b1;
        tick();
        start = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr err_cnt", 64'(err_cnt), 64'd0);
        check("clr core_err", 64'(core_err), 64'd0);
        lat = 2;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("clr final err_cnt", 64'(err_cnt), 64'd15);
        check("clr final core_err", 64'(core_err), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
